// File: rtl/nibble_pkg.sv
// Shared nibble-processor definitions: field widths, result entry layout and
// opcode bit positions used by the result capture path.
package nibble_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 3;
  localparam int INST_W = 24;

  // Opcode field bit positions
  localparam int OP_MEM_BIT  = 0;
  localparam int OP_NEG_BIT  = 1;
  localparam int OP_CTRL_BIT = 2;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] r;
  } result_entry_t;

  localparam int ENTRY_W = $bits(result_entry_t);
endpackage

// File: rtl/result_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module result_fifo_mem
  import nibble_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = ENTRY_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/result_out_fifo.sv
// Show-ahead FIFO capturing committed results {op, addr, r} for slow sinks.
// Optional saturating drop counter enabled by `define RESULT_FIFO_DROP_CNT_EN.
module result_out_fifo #(
  parameter  int DEPTH   = 8,
  parameter  int DATA_W  = nibble_pkg::DATA_W,
  parameter  int ADDR_W  = nibble_pkg::ADDR_W,
  parameter  int OP_W    = nibble_pkg::OP_W,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1,
  localparam int ENTRY_W = OP_W + ADDR_W + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [DATA_W-1:0]  r_in,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic [OP_W-1:0]    op_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_W-1:0] out_data,
  output logic [CNT_W-1:0]   count,
  output logic               full,
`ifdef RESULT_FIFO_DROP_CNT_EN
  output logic [7:0]         drop_count,
`endif
  output logic               overflow
);
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             w_empty, w_full, w_pop, w_push, w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = ~w_empty & out_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts it
  assign w_push  = wr_en & (~w_full | w_pop);
  assign w_drop  = wr_en & w_full & ~w_pop;

  result_fifo_mem #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_mem (
    .clk     (clk),
    .i_we    (w_push & ~reset),
    .i_waddr (r_wr_ptr),
    .i_wdata ({op_in, addr_in, r_in}),
    .i_raddr (r_rd_ptr),
    .o_rdata (out_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

`ifdef RESULT_FIFO_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign drop_count = r_drop_cnt;
`endif

  assign out_valid = ~w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign overflow  = r_overflow;
endmodule

// File: doc/result_out_fifo.md
Name: result_out_fifo

Overview:
- Downstream consumer of the processor's result register write strobe (en[0]).
- Captures each committed result as one entry {op, addr, r} into a small synchronous FIFO.
- Presents entries to an external sink over a valid/ready handshake.
- Decouples processor execution from slow observers: display driver, serial dumper, testbench monitor.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- DATA_W, 8, result/operand width.
- ADDR_W, 5, RAM address width.
- OP_W, 3, opcode width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  result commit strobe (the R-register enable).
- r_in  input  DATA_W  result value being committed.
- addr_in  input  ADDR_W  address field of the committing instruction.
- op_in  input  OP_W  opcode of the committing instruction.
- out_valid  output  1  head entry available.
- out_ready  input  1  sink accepts the head entry.
- out_data  output  OP_W+ADDR_W+DATA_W  {op, addr, r} of the head entry (16 bits at defaults).
- count  output  $clog2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a push was dropped.

Behaviour:
- One clock domain. Reset is asynchronous and active-high. All state clears on assertion: rd_ptr=0, wr_ptr=0, count=0, overflow=0, so out_valid=0, full=0. Storage contents are not reset; out_data is don't-care while out_valid=0.
- Push: wr_en=1 at a rising edge writes {op_in, addr_in, r_in} at wr_ptr, increments wr_ptr mod DEPTH, and increments count.
- Pop: out_valid & out_ready at a rising edge increments rd_ptr mod DEPTH and decrements count.
- Show-ahead read:
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr], combinational from registered storage.
  - No bubble between back-to-back pops.
- Latency: an entry pushed at edge N is visible (out_valid=1, out_data valid) in the cycle after edge N. Write-to-read cannot bypass on the same edge.
- Simultaneous push and pop:
  - Not full: both occur, count unchanged.
  - Full: the pop frees a slot, so the push is accepted and count stays DEPTH.
  - Empty: the pop is ignored (out_valid=0) and the push is accepted.
- Full, no pop, wr_en=1: entry dropped, storage and pointers unchanged, overflow set to 1.
- overflow is cleared only by reset.
- out_ready while empty: no effect.
- out_data must hold stable while out_valid=1 and out_ready=0. The sink may sample out_data on any cycle.
- Pointers wrap naturally using log2(DEPTH) bits. count is a separate register; full and empty are derived from it.
- Reset asserted mid-stream: immediate clear, and no partial push or pop completes on that edge.

Optional Feature:
- Macro RESULT_FIFO_DROP_CNT_EN.
- Defined: adds output drop_count [7:0], which increments on every dropped push, saturates at 255, and resets to 0.
- Undefined: the port and counter are absent; only the sticky overflow flag reports drops.

Decomposition:
- Shared package nibble_pkg holds:
  - constants DATA_W=8, ADDR_W=5, OP_W=3, INST_W=24;
  - typedef result_entry_t packed struct {op, addr, r};
  - opcode field bit-position constants (op[0] memory select, op[1] negate, op[2] control).
- One natural sub-module, result_fifo_mem: DEPTH x entry register array with one write port and one asynchronous read port.
- Pointer, count and handshake logic stays in result_out_fifo.

Test Plan:
- Reset, then 3 pushes {op=3'b001, addr=5'd4, r=8'h12/8'h34/8'h56} with out_ready=0 -> count=3, out_valid=1, out_data=16'h2412; after raising out_ready, the three entries drain in order over 3 cycles and count=0.
- Push 8 entries with r=1..8 and no pop, then a 9th push with r=9 -> full=1, overflow=1, count=8, 9 is absent; draining returns 1..8. With RESULT_FIFO_DROP_CNT_EN, drop_count=1.
- Full FIFO, simultaneous push r=8'hAA with pop -> count stays 8; after draining, the last entry read is 8'hAA.
- Empty FIFO, wr_en=1 with out_ready=1 on the same edge -> no pop, count=1, out_valid=1 in the following cycle.
- Stream 20 pushes with out_ready toggling 1-0 -> order preserved across pointer wrap, and out_data holds stable during every stall cycle.
- Reset asserted asynchronously mid-cycle with count=5 and overflow=1 -> count=0, out_valid=0, overflow=0 before the next clock edge.
